mysystem_avm_loader: RTL and testbench

// - Avalon-MM master (initiator) driving the 32-bit register slaves on the mysystem fabric.
// - On start it streams NUM_WORDS words from a local source to consecutive slave word addresses.
// - It then polls a status word until the done bit is set and reads back one result word.
// - Used by the chess datapath to push a board and collect the computed move.

---
 rtl/mysystem_avm_pkg.sv | 22 ++
 rtl/mysystem_avm_loader_if.sv | 33 +++
 rtl/mysystem_poll_timer.sv | 26 ++
 rtl/mysystem_avm_loader.sv | 145 ++++++++++++++
 tb/tb_mysystem_avm_loader.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mysystem_avm_pkg.sv
// Shared state encoding and default fabric addresses for the mysystem
// Avalon-MM loader.
package mysystem_avm_pkg;

    localparam int DATA_W          = 32;
    localparam int DEF_ADDR_W      = 2;
    localparam int DEF_NUM_WORDS   = 4;
    localparam int DEF_BASE_ADDR   = 0;
    localparam int DEF_STATUS_ADDR = 3;
    localparam int DEF_STATUS_BIT  = 0;
    localparam int DEF_RESULT_ADDR = 0;
    localparam int DEF_TIMEOUT     = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_POLL,
        ST_RESULT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mysystem_avm_loader_if.sv
// Avalon-MM word-addressed bus between the loader (master) and the
// mysystem register slaves.
interface mysystem_avm_loader_if #(
    parameter int ADDR_W = 2
);
    import mysystem_avm_pkg::*;

    logic [ADDR_W-1:0] avm_address;
    logic              avm_write;
    logic              avm_read;
    logic [DATA_W-1:0] avm_writedata;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_waitrequest;

    modport master (
        output avm_address,
        output avm_write,
        output avm_read,
        output avm_writedata,
        input  avm_readdata,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_write,
        input  avm_read,
        input  avm_writedata,
        output avm_readdata,
        output avm_waitrequest
    );

endinterface

// File: rtl/mysystem_poll_timer.sv
// Clearable, enabled cycle counter that flags the last allowed poll cycle.
// A TIMEOUT of 0 disables the terminal count entirely.
module mysystem_poll_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (TIMEOUT != 0) && enable && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mysystem_avm_loader.sv
// Avalon-MM loader: streams a job of source words to consecutive slave
// addresses, polls a status word until ready, then fetches one result word.
module mysystem_avm_loader
    import mysystem_avm_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int NUM_WORDS   = DEF_NUM_WORDS,
    parameter int BASE_ADDR   = DEF_BASE_ADDR,
    parameter int STATUS_ADDR = DEF_STATUS_ADDR,
    parameter int STATUS_BIT  = DEF_STATUS_BIT,
    parameter int RESULT_ADDR = DEF_RESULT_ADDR,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DATA_W-1:0]     src_data,
    input  logic                  src_valid,
    output logic                  src_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [DATA_W-1:0]     result,
    mysystem_avm_loader_if.master avm
);
    state_t            state;
    state_t            state_d;
    logic [ADDR_W-1:0] word_cnt;
    logic              wr_pend;
    logic              poll_gap;
    logic              error_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] result_q;
    logic              rd_strobe;
    logic              wr_done;
    logic              rd_done;
    logic              status_set;
    logic              last_word;
    logic              src_fire;
    logic              tmo_expired;

    assign wr_done    = wr_pend && !avm.avm_waitrequest;
    assign rd_done    = rd_strobe && !avm.avm_waitrequest;
    assign status_set = avm.avm_readdata[STATUS_BIT];
    assign last_word  = (word_cnt == ADDR_W'(NUM_WORDS - 1));
    assign src_fire   = src_valid && src_ready;

    mysystem_poll_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_poll_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state != ST_POLL),
        .enable  (state == ST_POLL),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // A ready status bit wins over a timeout landing in the same cycle.
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:   if (start) state_d = ST_WRITE;
            ST_WRITE:  if (wr_done && last_word) state_d = ST_POLL;
            ST_POLL: begin
                if (rd_done && status_set) begin
                    state_d = ST_RESULT;
                end else if (tmo_expired) begin
                    state_d = ST_DONE;
                end
            end
            ST_RESULT: if (rd_done) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        src_ready       = 1'b0;
        rd_strobe       = 1'b0;
        avm.avm_address = '0;
        busy            = (state != ST_IDLE);
        done            = (state == ST_DONE);
        case (state)
            ST_WRITE: begin
                src_ready       = !wr_pend;
                avm.avm_address = ADDR_W'(BASE_ADDR) + word_cnt;
            end
            ST_POLL: begin
                rd_strobe       = !poll_gap;
                avm.avm_address = ADDR_W'(STATUS_ADDR);
            end
            ST_RESULT: begin
                rd_strobe       = 1'b1;
                avm.avm_address = ADDR_W'(RESULT_ADDR);
            end
            default: ;
        endcase
        avm.avm_read = rd_strobe;
    end

    assign avm.avm_write     = wr_pend;
    assign avm.avm_writedata = wdata_q;
    assign error             = error_q;
    assign result            = result_q;

    // Write strobe and data are registered so they hold through any stall.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            word_cnt <= '0;
            wr_pend  <= 1'b0;
            wdata_q  <= '0;
            poll_gap <= 1'b0;
            error_q  <= 1'b0;
            result_q <= '0;
        end else begin
            if (state == ST_IDLE && start) begin
                word_cnt <= '0;
                error_q  <= 1'b0;
            end
            if (src_fire) begin
                wdata_q <= src_data;
                wr_pend <= 1'b1;
            end else if (wr_done) begin
                wr_pend  <= 1'b0;
                word_cnt <= word_cnt + 1'b1;
            end
            poll_gap <= (state == ST_POLL) && (state_d == ST_POLL) && rd_done && !status_set;
            if (state == ST_POLL && state_d == ST_DONE) begin
                error_q <= 1'b1;
            end
            if (state == ST_RESULT && rd_done) begin
                result_q <= avm.avm_readdata;
            end
        end
    end

endmodule

// File: tb/tb_mysystem_avm_loader.sv
// Directed bench for mysystem_avm_loader: one DUT with default timeout on a
// stallable slave, one with TIMEOUT=8 on a slave whose status can be held low.
module tb_mysystem_avm_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start1, src_valid1, src_ready1, busy1, done1, error1;
    logic [31:0] src_data1, result1;
    logic        start2, src_valid2, src_ready2, busy2, done2, error2;
    logic [31:0] src_data2, result2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mysystem_avm_loader_if #(.ADDR_W(2)) bus1 ();
    mysystem_avm_loader_if #(.ADDR_W(2)) bus2 ();

    mysystem_avm_loader dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start1),
        .src_data  (src_data1),
        .src_valid (src_valid1),
        .src_ready (src_ready1),
        .busy      (busy1),
        .done      (done1),
        .error     (error1),
        .result    (result1),
        .avm       (bus1.master)
    );

    mysystem_avm_loader #(.TIMEOUT(8)) dut_tmo (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start2),
        .src_data  (src_data2),
        .src_valid (src_valid2),
        .src_ready (src_ready2),
        .busy      (busy2),
        .done      (done2),
        .error     (error2),
        .result    (result2),
        .avm       (bus2.master)
    );

    // Slave 1: word memory, status at address 3 set after status_after reads,
    // and an optional write stall on address 2.
    int          stall_cfg    = 0;
    int          status_after = 0;
    logic        clr_slave    = 1'b1;
    int          stall_used   = 0;
    int          status_reads = 0;
    logic [31:0] mem1 [4];

    always_comb begin
        bus1.avm_waitrequest = bus1.avm_write && (bus1.avm_address == 2'd2) && (stall_used < stall_cfg);
        if (bus1.avm_address == 2'd3) bus1.avm_readdata = {31'd0, status_reads >= status_after};
        else bus1.avm_readdata = mem1[bus1.avm_address];
    end

    always @(posedge clk) begin
        if (clr_slave) begin
            stall_used   <= 0;
            status_reads <= 0;
        end else begin
            if (bus1.avm_waitrequest) stall_used <= stall_used + 1;
            if (bus1.avm_read && !bus1.avm_waitrequest && bus1.avm_address == 2'd3)
                status_reads <= status_reads + 1;
        end
        if (bus1.avm_write && !bus1.avm_waitrequest) mem1[bus1.avm_address] <= bus1.avm_writedata;
    end

    logic status2_on = 1'b1;
    assign bus2.avm_waitrequest = 1'b0;
    assign bus2.avm_readdata    = (bus2.avm_address == 2'd3) ? {31'd0, status2_on} : 32'h1234_5678;

    int          cyc = 0;
    logic [1:0]  wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    logic [1:0]  rd_addr_q [$];
    int          rd_cyc_q  [$];
    logic [1:0]  st_addr_q [$];
    logic [31:0] st_data_q [$];
    logic        st_rdy_q  [$];
    logic [1:0]  rd2_addr_q [$];
    int          rd2_cyc_q  [$];
    int          dn2_cyc_q  [$];
    int          done_cnt1 = 0;
    int          both_cnt  = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus1.avm_write && !bus1.avm_waitrequest) begin
            wr_addr_q.push_back(bus1.avm_address);
            wr_data_q.push_back(bus1.avm_writedata);
        end
        if (bus1.avm_read && !bus1.avm_waitrequest) begin
            rd_addr_q.push_back(bus1.avm_address);
            rd_cyc_q.push_back(cyc);
        end
        if (bus1.avm_write && bus1.avm_waitrequest) begin
            st_addr_q.push_back(bus1.avm_address);
            st_data_q.push_back(bus1.avm_writedata);
            st_rdy_q.push_back(src_ready1);
        end
        if (bus2.avm_read && !bus2.avm_waitrequest) begin
            rd2_addr_q.push_back(bus2.avm_address);
            rd2_cyc_q.push_back(cyc);
        end
        if (done2) dn2_cyc_q.push_back(cyc);
        if (done1) done_cnt1 <= done_cnt1 + 1;
        if ((bus1.avm_read && bus1.avm_write) || (bus2.avm_read && bus2.avm_write)) both_cnt <= both_cnt + 1;
    end

    function automatic logic [31:0] wordVal(input int k);
        return 32'hCAFE_00A0 + k;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one four-word job on DUT sel; start_at>0 re-pulses start that many
    // cycles after the last source handshake.
    task automatic applyStimulus(input bit sel, input int start_at, output bit ok);
        int n;
        ok = 1'b1;
        if (sel) start2 = 1'b1;
        else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (sel) begin src_data2 = wordVal(k); src_valid2 = 1'b1; end
            else begin src_data1 = wordVal(k); src_valid1 = 1'b1; end
            n = 0;
            while (!(sel ? src_ready2 : src_ready1) && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n >= 50) ok = 1'b0;
            @(negedge clk);
            src_valid1 = 1'b0;
            src_valid2 = 1'b0;
        end
        n = 0;
        while (!(sel ? done2 : done1) && n < 300) begin
            @(negedge clk);
            n++;
            start1 = !sel && (n == start_at);
        end
        start1 = 1'b0;
        if (n >= 300) ok = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit ok;
        int wb, rb, sb, db, rb2, db2;
        reset_n = 1'b0;
        start1 = 1'b0; src_valid1 = 1'b0; src_data1 = '0;
        start2 = 1'b0; src_valid2 = 1'b0; src_data2 = '0;
        repeat (3) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_src_ready", src_ready1, 0);
        checkOutput("rst_busy", busy1, 0);
        checkOutput("rst_done", done1, 0);
        checkOutput("rst_error", error1, 0);
        checkOutput("rst_result", result1, 0);
        checkOutput("rst_address", bus1.avm_address, 0);
        checkOutput("rst_write", bus1.avm_write, 0);
        checkOutput("rst_read", bus1.avm_read, 0);
        checkOutput("rst_writedata", bus1.avm_writedata, 0);
        checkOutput("rst_busy2", busy2, 0);
        reset_n = 1'b1;
        clr_slave = 1'b0;
        @(negedge clk);

        $display("[TB] zero-wait job");
        wb = wr_addr_q.size(); rb = rd_addr_q.size(); db = done_cnt1;
        applyStimulus(1'b0, -1, ok);
        repeat (3) @(negedge clk);
        checkOutput("t1_job", ok, 1);
        checkOutput("t1_nwr", wr_addr_q.size() - wb, 4);
        for (int k = 0; k < 4 && wb + k < wr_addr_q.size(); k++) begin
            checkOutput($sformatf("t1_wa%0d", k), wr_addr_q[wb + k], k);
            checkOutput($sformatf("t1_wd%0d", k), wr_data_q[wb + k], wordVal(k));
        end
        checkOutput("t1_nrd", rd_addr_q.size() - rb, 2);
        if (rd_addr_q.size() >= rb + 2) begin
            checkOutput("t1_ra0", rd_addr_q[rb], 3);
            checkOutput("t1_ra1", rd_addr_q[rb + 1], 0);
        end
        checkOutput("t1_result", result1, wordVal(0));
        checkOutput("t1_ndone", done_cnt1 - db, 1);
        checkOutput("t1_error", error1, 0);
        checkOutput("t1_busy", busy1, 0);

        $display("[TB] write stall on word 2");
        stall_cfg = 3;
        clr_slave = 1'b1; @(negedge clk); clr_slave = 1'b0;
        wb = wr_addr_q.size(); sb = st_addr_q.size();
        applyStimulus(1'b0, -1, ok);
        repeat (3) @(negedge clk);
        checkOutput("t2_job", ok, 1);
        checkOutput("t2_nstall", st_addr_q.size() - sb, 3);
        for (int k = sb; k < st_addr_q.size(); k++) begin
            checkOutput($sformatf("t2_sa%0d", k - sb), st_addr_q[k], 2);
            checkOutput($sformatf("t2_sd%0d", k - sb), st_data_q[k], wordVal(2));
            checkOutput($sformatf("t2_srdy%0d", k - sb), st_rdy_q[k], 0);
        end
        checkOutput("t2_nwr", wr_addr_q.size() - wb, 4);
        if (wr_addr_q.size() >= wb + 3) checkOutput("t2_wd2", wr_data_q[wb + 2], wordVal(2));
        checkOutput("t2_result", result1, wordVal(0));
        stall_cfg = 0;

        $display("[TB] status on 5th poll, start during POLL");
        status_after = 4;
        clr_slave = 1'b1; @(negedge clk); clr_slave = 1'b0;
        wb = wr_addr_q.size(); rb = rd_addr_q.size(); db = done_cnt1;
        applyStimulus(1'b0, 3, ok);
        repeat (10) @(negedge clk);
        checkOutput("t3_job", ok, 1);
        checkOutput("t3_nrd", rd_addr_q.size() - rb, 6);
        if (rd_addr_q.size() >= rb + 6) begin
            for (int i = 0; i < 5; i++) checkOutput($sformatf("t3_ra%0d", i), rd_addr_q[rb + i], 3);
            for (int i = 0; i < 4; i++)
                checkOutput($sformatf("t3_gap%0d", i), rd_cyc_q[rb + i + 1] - rd_cyc_q[rb + i], 2);
            checkOutput("t3_ra_result", rd_addr_q[rb + 5], 0);
            checkOutput("t3_result_lat", rd_cyc_q[rb + 5] - rd_cyc_q[rb + 4], 1);
        end
        checkOutput("t3_ndone", done_cnt1 - db, 1);
        checkOutput("t3_nwr", wr_addr_q.size() - wb, 4);
        checkOutput("t3_busy", busy1, 0);

        $display("[TB] reset during word 1 write");
        status_after = 0;
        clr_slave = 1'b1; @(negedge clk); clr_slave = 1'b0;
        start1 = 1'b1; @(negedge clk); start1 = 1'b0;
        src_data1 = wordVal(0); src_valid1 = 1'b1; @(negedge clk); src_valid1 = 1'b0;
        @(negedge clk);
        src_data1 = wordVal(1); src_valid1 = 1'b1; @(negedge clk); src_valid1 = 1'b0;
        checkOutput("t4_pre_write", bus1.avm_write, 1);
        checkOutput("t4_pre_addr", bus1.avm_address, 1);
        reset_n = 1'b0;
        @(negedge clk);
        checkOutput("t4_write", bus1.avm_write, 0);
        checkOutput("t4_read", bus1.avm_read, 0);
        checkOutput("t4_address", bus1.avm_address, 0);
        checkOutput("t4_writedata", bus1.avm_writedata, 0);
        checkOutput("t4_src_ready", src_ready1, 0);
        checkOutput("t4_busy", busy1, 0);
        checkOutput("t4_result", result1, 0);
        reset_n = 1'b1;
        @(negedge clk);
        wb = wr_addr_q.size(); db = done_cnt1;
        applyStimulus(1'b0, -1, ok);
        repeat (3) @(negedge clk);
        checkOutput("t4_job", ok, 1);
        checkOutput("t4_nwr", wr_addr_q.size() - wb, 4);
        if (wr_addr_q.size() > wb) begin
            checkOutput("t4_first_addr", wr_addr_q[wb], 0);
            checkOutput("t4_first_data", wr_data_q[wb], wordVal(0));
        end
        checkOutput("t4_ndone", done_cnt1 - db, 1);

        $display("[TB] timeout DUT");
        status2_on = 1'b1;
        applyStimulus(1'b1, -1, ok);
        repeat (3) @(negedge clk);
        checkOutput("t5_job_ok", ok, 1);
        checkOutput("t5_result_ok", result2, 32'h1234_5678);
        checkOutput("t5_error_ok", error2, 0);
        status2_on = 1'b0;
        rb2 = rd2_addr_q.size(); db2 = dn2_cyc_q.size();
        applyStimulus(1'b1, -1, ok);
        repeat (3) @(negedge clk);
        checkOutput("t5_job_tmo", ok, 1);
        checkOutput("t5_error_tmo", error2, 1);
        checkOutput("t5_result_held", result2, 32'h1234_5678);
        checkOutput("t5_nrd", rd2_addr_q.size() - rb2, 4);
        for (int k = rb2; k < rd2_addr_q.size(); k++)
            checkOutput($sformatf("t5_ra%0d", k - rb2), rd2_addr_q[k], 3);
        if (rd2_cyc_q.size() > rb2 && dn2_cyc_q.size() > db2)
            checkOutput("t5_done_cycle", dn2_cyc_q[db2] - rd2_cyc_q[rb2], 8);
        else
            checkOutput("t5_done_seen", dn2_cyc_q.size() - db2, 1);
        status2_on = 1'b1;
        applyStimulus(1'b1, -1, ok);
        repeat (3) @(negedge clk);
        checkOutput("t6_job", ok, 1);
        checkOutput("t6_error_cleared", error2, 0);
        checkOutput("t6_busy", busy2, 0);

        checkOutput("read_write_exclusive", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
